// File: rtl/popcount_acc_pipe.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : popcount_acc_pipe
// Brief   : Pipelined 5:3-counter population count with per-frame running
//           total. Define POPCNT_SAT_EN for a saturating accumulator.
// Rev     : 1.0  initial release
// ============================================================================
module popcount_acc_pipe #(
    parameter  int N_IN  = 15,
    parameter  int PIPE  = 2,
    parameter  int ACC_W = 16,
    localparam int CNT_W = $clog2(N_IN + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N_IN-1:0]  in_bits,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] out_count,
    output logic [ACC_W-1:0] out_acc,
    output logic             out_last,
    output logic             out_ovf
);

    localparam int NG    = (N_IN + 4) / 5;
    localparam int NP    = NG * 5;
    localparam int LVL   = $clog2(NG);
    localparam int SREG  = (PIPE > 1) ? PIPE - 1 : 1;
    localparam int ACC_X = ACC_W + 1;

    typedef logic [NG-1:0][CNT_W-1:0]   sums_t;
    typedef logic [2*NG-1:0][CNT_W-1:0] wide_t;

    generate
        if (N_IN < 5 || N_IN > 64 || PIPE < 1 || PIPE > 4 || ACC_W < CNT_W) begin : g_param_check
            $error("popcount_acc_pipe: illegal parameter combination");
        end
    endgenerate

    // 5:3 counter cell: ones in a 5-bit group, 0..5
    function automatic logic [2:0] count5(input logic [4:0] g);
        return {2'b00, g[0]} + {2'b00, g[1]} + {2'b00, g[2]}
             + {2'b00, g[3]} + {2'b00, g[4]};
    endfunction

    // Stage 1 only counts groups; the tree is split over the later stages
    // and any remainder lands in the output stage.
    function automatic int stage_levels(input int s);
        if (PIPE == 1) return LVL;
        if (s == 1)    return 0;
        if (s == PIPE) return LVL / (PIPE - 1) + LVL % (PIPE - 1);
        return LVL / (PIPE - 1);
    endfunction

    // Entries beyond the live width are always zero, so pairing into a
    // zero-padded copy needs no bound tracking.
    function automatic sums_t tree_reduce(input sums_t a, input int levels);
        sums_t cur;
        wide_t wide;
        cur = a;
        for (int l = 0; l < LVL; l++) begin
            if (l < levels) begin
                wide         = '0;
                wide[NG-1:0] = cur;
                for (int i = 0; i < NG; i++)
                    cur[i] = wide[2*i] + wide[2*i+1];
            end
        end
        return cur;
    endfunction

    logic [PIPE:0]    r_vld;
    logic [PIPE-1:0]  r_lst;
    logic [N_IN-1:0]  r_bits;
    sums_t            r_sum [SREG];
    logic [CNT_W-1:0] r_cnt;
    logic [ACC_W-1:0] r_acc;
    logic             r_out_last;
    logic             r_ovf;

    logic [NP-1:0]    w_padded;
    sums_t            w_groups;
    sums_t            w_stage [1:PIPE];
    logic             w_adv;
    logic [CNT_W-1:0] w_cnt;
    logic [ACC_W-1:0] w_acc_base;
    logic             w_ovf_base;
    logic [ACC_X-1:0] w_sum;
    logic [ACC_W-1:0] w_acc_next;
    logic             w_ovf_next;

    assign w_padded = NP'(r_bits);

    generate
        for (genvar g = 0; g < NG; g++) begin : g_group
            assign w_groups[g] = CNT_W'(count5(w_padded[5*g +: 5]));
        end

        for (genvar s = 1; s <= PIPE; s++) begin : g_stage
            localparam int LV = stage_levels(s);
            if (s == 1) begin : g_first
                assign w_stage[s] = tree_reduce(w_groups, LV);
            end else begin : g_tree
                assign w_stage[s] = tree_reduce(r_sum[s-2], LV);
            end
        end
    endgenerate

    assign w_adv    = !(r_vld[PIPE] && !out_ready);
    assign in_ready = !clear && w_adv;
    assign w_cnt    = w_stage[PIPE][0];

    // A new frame starts after a last beat (or after reset/clear, where
    // r_acc and r_ovf are already zero).
    assign w_acc_base = r_out_last ? '0 : r_acc;
    assign w_ovf_base = r_out_last ? 1'b0 : r_ovf;
    assign w_sum      = {1'b0, w_acc_base} + ACC_X'(w_cnt);
    assign w_ovf_next = w_ovf_base | w_sum[ACC_W];

`ifdef POPCNT_SAT_EN
    assign w_acc_next = (w_sum[ACC_W] || w_ovf_base) ? {ACC_W{1'b1}} : w_sum[ACC_W-1:0];
`else
    assign w_acc_next = w_sum[ACC_W-1:0];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld      <= '0;
            r_lst      <= '0;
            r_bits     <= '0;
            for (int i = 0; i < SREG; i++)
                r_sum[i] <= '0;
            r_cnt      <= '0;
            r_acc      <= '0;
            r_out_last <= 1'b0;
            r_ovf      <= 1'b0;
        end else if (clear) begin
            r_vld      <= '0;
            r_cnt      <= '0;
            r_acc      <= '0;
            r_out_last <= 1'b0;
            r_ovf      <= 1'b0;
        end else if (w_adv) begin
            r_vld[0] <= in_valid;
            r_lst[0] <= in_last;
            r_bits   <= in_bits;
            for (int s = 1; s < PIPE; s++) begin
                r_vld[s]   <= r_vld[s-1];
                r_lst[s]   <= r_lst[s-1];
                r_sum[s-1] <= w_stage[s];
            end
            r_vld[PIPE] <= r_vld[PIPE-1];
            if (r_vld[PIPE-1]) begin
                r_cnt      <= w_cnt;
                r_acc      <= w_acc_next;
                r_ovf      <= w_ovf_next;
                r_out_last <= r_lst[PIPE-1];
            end
        end
    end

    assign out_valid = r_vld[PIPE];
    assign out_count = r_cnt;
    assign out_acc   = r_acc;
    assign out_last  = r_out_last;
    assign out_ovf   = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_popcount_acc_pipe.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : tb_popcount_acc_pipe
// Brief   : Directed self-checking bench for popcount_acc_pipe.
// Rev     : 1.0  initial release
// ============================================================================
module tb_popcount_acc_pipe;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Default instance (ACC_W=16)
    logic        clear     = 1'b0;
    logic        in_valid  = 1'b0;
    logic        in_ready;
    logic [14:0] in_bits   = '0;
    logic        in_last   = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [3:0]  out_count;
    logic [15:0] out_acc;
    logic        out_last;
    logic        out_ovf;

    // Narrow-accumulator instance (ACC_W=5)
    logic        b_clear     = 1'b0;
    logic        b_in_valid  = 1'b0;
    logic        b_in_ready;
    logic [14:0] b_in_bits   = '0;
    logic        b_in_last   = 1'b0;
    logic        b_out_valid;
    logic        b_out_ready = 1'b1;
    logic [3:0]  b_out_count;
    logic [4:0]  b_out_acc;
    logic        b_out_last;
    logic        b_out_ovf;

    logic [22:0] obs_a;
    logic [11:0] obs_b;
    assign obs_a = {out_valid, out_count, out_acc, out_last, out_ovf};
    assign obs_b = {b_out_valid, b_out_count, b_out_acc, b_out_last, b_out_ovf};

    popcount_acc_pipe #(.N_IN(15), .PIPE(2), .ACC_W(16)) u_dut (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .in_valid(in_valid), .in_ready(in_ready), .in_bits(in_bits), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_count(out_count),
        .out_acc(out_acc), .out_last(out_last), .out_ovf(out_ovf)
    );

    popcount_acc_pipe #(.N_IN(15), .PIPE(2), .ACC_W(5)) u_dut_ovf (
        .clk(clk), .rst_n(rst_n), .clear(b_clear),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_bits(b_in_bits), .in_last(b_in_last),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_count(b_out_count),
        .out_acc(b_out_acc), .out_last(b_out_last), .out_ovf(b_out_ovf)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #2;
        tests++;
        if (obs_a !== 23'd0) begin
            fails++;
            $display("FAIL reset_outputs: got %h expected %h", obs_a, 23'd0);
        end
        tests++;
        if (obs_b !== 12'd0) begin
            fails++;
            $display("FAIL reset_outputs_b: got %h expected %h", obs_b, 12'd0);
        end
        step();
        step();
        rst_n = 1'b1;
        step();
        tests++;
        if (in_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_in_ready: got %b expected 1", in_ready);
        end
    endtask

    task automatic test_single();
        logic [22:0] exp_v;
        in_valid = 1'b1; in_bits = 15'h7FFF; in_last = 1'b1;
        step();
        in_valid = 1'b0; in_bits = '0; in_last = 1'b0;
        step();
        tests++;
        if (out_valid !== 1'b0) begin
            fails++;
            $display("FAIL single_latency_early: out_valid got %b expected 0", out_valid);
        end
        step();
        exp_v = {1'b1, 4'd15, 16'd15, 1'b1, 1'b0};
        tests++;
        if (obs_a !== exp_v) begin
            fails++;
            $display("FAIL single_beat: got %h expected %h", obs_a, exp_v);
        end
        step();
        tests++;
        if (out_valid !== 1'b0) begin
            fails++;
            $display("FAIL single_drain: out_valid got %b expected 0", out_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [14:0] bits [3] = '{15'h0001, 15'h0003, 15'h0007};
        logic [3:0]  ecnt [3] = '{4'd1, 4'd2, 4'd3};
        logic [15:0] eacc [3] = '{16'd1, 16'd3, 16'd6};
        logic [22:0] exp_v;
        for (int c = 0; c < 5; c++) begin
            if (c < 3) begin
                in_valid = 1'b1; in_bits = bits[c]; in_last = (c == 2);
            end else begin
                in_valid = 1'b0; in_bits = '0; in_last = 1'b0;
            end
            step();
            if (c >= 2) begin
                exp_v = {1'b1, ecnt[c-2], eacc[c-2], (c == 4), 1'b0};
                tests++;
                if (obs_a !== exp_v) begin
                    fails++;
                    $display("FAIL b2b_beat%0d: got %h expected %h", c - 2, obs_a, exp_v);
                end
            end
        end
        step();
        tests++;
        if (out_valid !== 1'b0) begin
            fails++;
            $display("FAIL b2b_drain: out_valid got %b expected 0", out_valid);
        end
    endtask

    task automatic test_stall();
        logic [22:0] exp_v;
        in_valid = 1'b1; in_bits = 15'h0001; in_last = 1'b0;
        step();
        in_bits = 15'h0003;
        step();
        in_bits = 15'h0007; in_last = 1'b1;
        step();
        in_valid = 1'b0; in_bits = '0; in_last = 1'b0; out_ready = 1'b0;
        #1;
        tests++;
        if (in_ready !== 1'b0) begin
            fails++;
            $display("FAIL stall_in_ready: got %b expected 0", in_ready);
        end
        exp_v = {1'b1, 4'd1, 16'd1, 1'b0, 1'b0};
        for (int i = 0; i < 4; i++) begin
            step();
            tests++;
            if (obs_a !== exp_v) begin
                fails++;
                $display("FAIL stall_hold%0d: got %h expected %h", i, obs_a, exp_v);
            end
        end
        out_ready = 1'b1;
        step();
        exp_v = {1'b1, 4'd2, 16'd3, 1'b0, 1'b0};
        tests++;
        if (obs_a !== exp_v) begin
            fails++;
            $display("FAIL stall_release1: got %h expected %h", obs_a, exp_v);
        end
        step();
        exp_v = {1'b1, 4'd3, 16'd6, 1'b1, 1'b0};
        tests++;
        if (obs_a !== exp_v) begin
            fails++;
            $display("FAIL stall_release2: got %h expected %h", obs_a, exp_v);
        end
        step();
        tests++;
        if (out_valid !== 1'b0) begin
            fails++;
            $display("FAIL stall_no_dup: out_valid got %b expected 0", out_valid);
        end
    endtask

    task automatic test_zero();
        logic [22:0] exp_v;
        for (int c = 0; c < 4; c++) begin
            if (c == 0) begin
                in_valid = 1'b1; in_bits = 15'h0000; in_last = 1'b0;
            end else if (c == 1) begin
                in_valid = 1'b1; in_bits = 15'h0006; in_last = 1'b1;
            end else begin
                in_valid = 1'b0; in_bits = '0; in_last = 1'b0;
            end
            step();
            if (c == 2) begin
                exp_v = {1'b1, 4'd0, 16'd0, 1'b0, 1'b0};
                tests++;
                if (obs_a !== exp_v) begin
                    fails++;
                    $display("FAIL zero_beat: got %h expected %h", obs_a, exp_v);
                end
            end else if (c == 3) begin
                exp_v = {1'b1, 4'd2, 16'd2, 1'b1, 1'b0};
                tests++;
                if (obs_a !== exp_v) begin
                    fails++;
                    $display("FAIL zero_next: got %h expected %h", obs_a, exp_v);
                end
            end
        end
        step();
    endtask

    task automatic test_clear();
        logic [22:0] exp_v;
        in_valid = 1'b1; in_bits = 15'h0007; in_last = 1'b0;
        step();
        in_bits = 15'h0003;
        step();
        in_bits = 15'h000F;
        step();
        exp_v = {1'b1, 4'd3, 16'd3, 1'b0, 1'b0};
        tests++;
        if (obs_a !== exp_v) begin
            fails++;
            $display("FAIL clear_pre: got %h expected %h", obs_a, exp_v);
        end
        clear = 1'b1; out_ready = 1'b0; in_bits = 15'h7FFF; in_valid = 1'b1;
        #1;
        tests++;
        if (in_ready !== 1'b0) begin
            fails++;
            $display("FAIL clear_in_ready: got %b expected 0", in_ready);
        end
        step();
        clear = 1'b0; in_valid = 1'b0; in_bits = '0; out_ready = 1'b1;
        tests++;
        if ({out_valid, out_acc, out_ovf} !== 18'd0) begin
            fails++;
            $display("FAIL clear_flush: got %h expected %h", {out_valid, out_acc, out_ovf}, 18'd0);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            tests++;
            if (out_valid !== 1'b0) begin
                fails++;
                $display("FAIL clear_drop%0d: out_valid got %b expected 0", i, out_valid);
            end
        end
        in_valid = 1'b1; in_bits = 15'h0005; in_last = 1'b1;
        step();
        in_valid = 1'b0; in_bits = '0; in_last = 1'b0;
        step();
        step();
        exp_v = {1'b1, 4'd2, 16'd2, 1'b1, 1'b0};
        tests++;
        if (obs_a !== exp_v) begin
            fails++;
            $display("FAIL clear_next_beat: got %h expected %h", obs_a, exp_v);
        end
        step();
    endtask

    task automatic test_overflow();
        logic [3:0]  ecnt  [5] = '{4'd15, 4'd15, 4'd15, 4'd15, 4'd1};
        logic [4:0]  eacc  [5];
        logic        eovf  [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        logic        elast [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [11:0] exp_v;
`ifdef POPCNT_SAT_EN
        eacc = '{5'd15, 5'd30, 5'd31, 5'd31, 5'd1};
`else
        eacc = '{5'd15, 5'd30, 5'd13, 5'd28, 5'd1};
`endif
        for (int c = 0; c < 7; c++) begin
            if (c < 5) begin
                b_in_valid = 1'b1;
                b_in_bits  = (c < 4) ? 15'h7FFF : 15'h0001;
                b_in_last  = (c >= 3);
            end else begin
                b_in_valid = 1'b0; b_in_bits = '0; b_in_last = 1'b0;
            end
            step();
            if (c >= 2) begin
                exp_v = {1'b1, ecnt[c-2], eacc[c-2], elast[c-2], eovf[c-2]};
                tests++;
                if (obs_b !== exp_v) begin
                    fails++;
                    $display("FAIL ovf_beat%0d: got %h expected %h", c - 2, obs_b, exp_v);
                end
            end
        end
        step();
    endtask

    task automatic test_async_reset();
        logic [22:0] exp_v;
        in_valid = 1'b1; in_bits = 15'h0007; in_last = 1'b0;
        step();
        in_bits = 15'h0001;
        step();
        in_valid = 1'b0; in_bits = '0;
        step();
        exp_v = {1'b1, 4'd3, 16'd3, 1'b0, 1'b0};
        tests++;
        if (obs_a !== exp_v) begin
            fails++;
            $display("FAIL areset_pre: got %h expected %h", obs_a, exp_v);
        end
        #3;
        rst_n = 1'b0;
        #1;
        tests++;
        if (obs_a !== 23'd0) begin
            fails++;
            $display("FAIL areset_immediate: got %h expected %h", obs_a, 23'd0);
        end
        #2;
        rst_n = 1'b1;
        step();
        in_valid = 1'b1; in_bits = 15'h001F; in_last = 1'b1;
        step();
        in_valid = 1'b0; in_bits = '0; in_last = 1'b0;
        step();
        tests++;
        if (out_valid !== 1'b0) begin
            fails++;
            $display("FAIL areset_stale: out_valid got %b expected 0", out_valid);
        end
        step();
        exp_v = {1'b1, 4'd5, 16'd5, 1'b1, 1'b0};
        tests++;
        if (obs_a !== exp_v) begin
            fails++;
            $display("FAIL areset_first_beat: got %h expected %h", obs_a, exp_v);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_stall();
        test_zero();
        test_clear();
        test_overflow();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/popcount_acc_pipe.md
Name: popcount_acc_pipe

Overview:
- Parametrised, pipelined population counter built from 5:3 counter cells.
- Counts the ones in an N_IN-bit input vector each accepted beat.
- Accumulates per-frame totals across beats, with valid/ready handshakes on both sides.
- Sits between bit-vector producers (match masks, syndrome vectors) and downstream statistics logic.

Parameters:
- N_IN, 15, input vector width; internally zero-padded to a multiple of 5; legal range 5..64.
- PIPE, 2, pipeline depth in cycles from input acceptance to output valid; legal range 1..4.
- ACC_W, 16, accumulator width; must be at least CNT_W.
- CNT_W, $clog2(N_IN+1), per-beat count width; derived, not overridable.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- clear  in  1  synchronous flush of pipeline and accumulator
- in_valid  in  1  input beat valid
- in_ready  out  1  block can accept a beat
- in_bits  in  N_IN  vector to count
- in_last  in  1  beat closes the current frame
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_count  out  CNT_W  ones in this beat
- out_acc  out  ACC_W  running frame total including this beat
- out_last  out  1  in_last delayed with its beat
- out_ovf  out  1  sticky per-frame accumulator overflow

Behaviour:
- Reset (rst_n low, asynchronous): all stage valids 0, accumulator 0, overflow flag 0. Outputs out_valid=0, out_count=0, out_acc=0, out_last=0, out_ovf=0.
- in_ready = !clear && !(out_valid && !out_ready).
- Accept: in_valid && in_ready at a rising edge.
- Stall: when out_valid && !out_ready, the whole pipeline holds and all outputs stay stable.
- Latency: a beat accepted at edge k presents out_valid after edge k+PIPE, provided there are no stalls.
- Throughput: one beat per cycle.
- Stage 1: padded vector split into 5-bit groups; each group reduced by a 5:3 counter to a 3-bit count 0..5.
- Remaining stages: counts summed by an adder tree. Tree levels are distributed over PIPE registers, with any surplus levels in the final stage.
- Accumulation is done at the output stage when a beat enters it: out_acc = acc_prev + out_count. acc_prev is 0 if the previous output beat had out_last=1 or none has been produced since reset/clear.
- Overflow: if the addition carries beyond ACC_W, the flag is set and held until the frame's out_last beat is accepted downstream. It then clears for the next frame.
- Frame boundary: the beat carrying out_last=1 shows the final frame total. The accumulator restarts at 0 for the following beat.
- clear (synchronous):
  - at the next edge, all stage valids, the accumulator and the overflow flag return to reset values;
  - any beat presented with in_valid in the same cycle is dropped (in_ready=0);
  - in-flight results are discarded;
  - clear wins over every simultaneous event, including a stall.
- Reset mid-frame: same effect as clear, but asynchronous.
- out_valid && !out_ready: out_count/out_acc/out_last/out_ovf must not change (AXI-style stability).
- in_bits all zero: out_count=0 and the accumulator is unchanged. It still produces an output beat.

Optional Feature:
- Macro POPCNT_SAT_EN.
- Defined: accumulator saturates at 2^ACC_W-1 on overflow and stays there until the frame ends; out_ovf behaves as above.
- Undefined: accumulator wraps modulo 2^ACC_W; out_ovf still flags the wrap.

Test Plan:
- Defaults, single beat in_bits=15'h7FFF, in_last=1 -> after 2 edges out_valid=1, out_count=15, out_acc=15, out_last=1.
- Three back-to-back beats with 0x0001, 0x0003, 0x0007 (last on third), out_ready=1 -> out_count 1,2,3; out_acc 1,3,6; one result per cycle.
- Same three beats with out_ready=0 for 4 cycles after the first result -> in_ready drops, outputs held stable; after release the sequence is 1,3,6 with no loss or duplication.
- ACC_W=5, four beats of 15'h7FFF in one frame -> totals 15,30, then overflow. Wrap build: 13, 28, out_ovf=1. POPCNT_SAT_EN build: 31, 31, out_ovf=1. Next frame starts at out_ovf=0.
- clear asserted while two beats are in flight and in_valid=1 -> no out_valid for those beats; next accepted beat 0x0005 gives out_acc=2.
- rst_n pulsed low mid-frame, asynchronously off-edge -> outputs zero immediately; first post-reset beat 0x001F gives out_count=5, out_acc=5.
